// File: rtl/mem_burst_reader_if.sv
// mem_burst_reader_if: memory read bus plus output stream handshake.
interface mem_burst_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] address;
  logic              read_signal;
  logic              write_signal;
  logic [DATA_W-1:0] data;
  logic              doneRead;
  logic [DATA_W-1:0] dataout;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  modport master (
    output address, read_signal, write_signal, data, out_data, out_valid,
    input  doneRead, dataout, out_ready
  );
  modport slave (
    input  address, read_signal, write_signal, data, out_data, out_valid,
    output doneRead, dataout, out_ready
  );
endinterface

// File: rtl/mem_burst_reader.sv
// mem_burst_reader: reads length consecutive words from memory and streams them out.
module mem_burst_reader #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [15:0]          length,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  mem_burst_reader_if.master   bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, address_q, address_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d, read_q, read_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    wait_cnt_d  = wait_cnt_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    if (state_q == IDLE) begin
      if (start && length == 16'd0) done_d = 1'b1;
      else if (start) begin
        state_d     = ISSUE;
        cur_addr_d  = base_addr;
        remaining_d = length;
      end
    end else if (abort) state_d = IDLE;
    else if (state_q == ISSUE) begin
      state_d    = WAIT;
      wait_cnt_d = '0;
    end else if (state_q == WAIT) begin
      if (bus.doneRead) begin
        state_d    = HOLD;
        out_data_d = bus.dataout;
      end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d = IDLE;
        error_d = 1'b1;
      end else wait_cnt_d = wait_cnt_q + 1'b1;
    end else if (bus.out_ready) begin
      if (remaining_q == 16'd1) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d     = ISSUE;
        remaining_d = remaining_q - 16'd1;
        cur_addr_d  = cur_addr_q + 1'b1;
      end
    end
    busy_d      = state_d != IDLE;
    read_d      = state_d == ISSUE;
    out_valid_d = state_d == HOLD;
    address_d   = busy_d ? cur_addr_d : '0;
  end
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      wait_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      read_q      <= 1'b0;
      address_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      wait_cnt_q  <= wait_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      read_q      <= read_d;
      address_q   <= address_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end
  assign bus.address      = address_q;
  assign bus.read_signal  = read_q;
  assign bus.write_signal = 1'b0;
  assign bus.data         = '0;
  assign bus.out_data     = out_data_q;
  assign bus.out_valid    = out_valid_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
endmodule

// File: tb/tb_mem_burst_reader.sv
// tb_mem_burst_reader: directed and random bursts against a transaction-level reference model.
module tb_mem_burst_reader;
  localparam int TO = 15;
  logic clk = 1'b0, RST = 1'b1, start = 1'b0, abort = 1'b0;
  logic [15:0] base_addr = '0, length = '0;
  logic busy, done, error;
  mem_burst_reader_if #(.ADDR_W(16), .DATA_W(8)) bus();
  mem_burst_reader #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .RST(RST), .start(start), .abort(abort), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .error(error), .bus(bus.master)
  );
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [7:0] mem [0:65535];
  int lat_mode = 0, rdy_mode = 0;
  bit pend = 0;
  int lat = 0;
  logic [15:0] rd_a = '0;

  int cyc = 0, busy_cnt = 0, done_cnt = 0, err_cnt = 0, last_rd_cyc = 0, err_cyc = 0;
  int rd_log[$];
  int hs_log[$];

  bit m_act = 0, m_done = 0, m_err = 0;
  int m_base = 0, m_len = 0, m_idx = 0, m_ph = 0, m_wait = 0;
  logic [7:0] m_dat = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr_logs();
    busy_cnt = 0; done_cnt = 0; err_cnt = 0;
    rd_log.delete(); hs_log.delete();
  endtask

  task automatic pulse_start(input logic [15:0] b, input logic [15:0] l);
    start = 1'b1; base_addr = b; length = l;
    step();
    start = 1'b0; base_addr = $urandom; length = $urandom;
  endtask

  task automatic run_until_idle(input int maxc, input string nm);
    int n = 0;
    do begin step(); n++; end while (busy && n < maxc);
    chk(nm, n < maxc, 1);
  endtask

  task automatic wait_valid(input int maxc, input string nm);
    int n = 0;
    while (!bus.out_valid && n < maxc) begin step(); n++; end
    chk(nm, n < maxc, 1);
  endtask

  // memory slave: samples the strobe on the falling edge, answers after lat WAIT cycles
  initial forever begin
    @(negedge clk);
    if (bus.read_signal) begin
      pend = 1; rd_a = bus.address;
      lat = lat_mode == 2 ? 1000 : lat_mode == 0 ? 0 :
            ($urandom_range(0, 9) == 0 ? TO + 1 : int'($urandom_range(0, 3)));
    end
  end

  initial begin
    bus.doneRead = 1'b0; bus.dataout = '0; bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.doneRead = 1'b0; bus.dataout = $urandom;
      if (pend) begin
        if (lat == 0) begin bus.doneRead = 1'b1; bus.dataout = mem[rd_a]; pend = 0; end
        else lat--;
      end
      bus.out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ($urandom_range(0, 9) < 7) : 1'b0;
    end
  end

  // reference model: a burst is length words, each word = one issue cycle,
  // up to TO wait cycles, then a hold until the consumer accepts it
  initial forever begin
    logic s_start, s_abort, s_dr, s_rdy;
    logic [15:0] s_base, s_len;
    logic [7:0] s_dout;
    @(posedge clk);
    s_start = start; s_abort = abort; s_dr = bus.doneRead; s_rdy = bus.out_ready;
    s_base = base_addr; s_len = length; s_dout = bus.dataout;
    m_done = 0; m_err = 0;
    if (!RST) begin m_act = 0; m_dat = '0; end
    else if (!m_act) begin
      if (s_start && s_len == 0) m_done = 1;
      else if (s_start) begin
        m_act = 1; m_base = s_base; m_len = s_len; m_idx = 0; m_ph = 0;
      end
    end else if (s_abort) m_act = 0;
    else if (m_ph == 0) begin m_ph = 1; m_wait = 0; end
    else if (m_ph == 1) begin
      if (s_dr) begin m_ph = 2; m_dat = s_dout; end
      else if (m_wait + 1 == TO) begin m_act = 0; m_err = 1; end
      else m_wait++;
    end else if (s_rdy) begin
      if (m_idx + 1 == m_len) begin m_act = 0; m_done = 1; end
      else begin m_idx++; m_ph = 0; end
    end
    @(negedge clk);
    if (!RST) begin m_act = 0; m_done = 0; m_err = 0; m_dat = '0; end
    cyc++;
    chk("busy", busy, m_act);
    chk("read_signal", bus.read_signal, m_act && m_ph == 0);
    chk("address", bus.address, m_act ? 32'((m_base + m_idx) % 65536) : 0);
    chk("out_valid", bus.out_valid, m_act && m_ph == 2);
    chk("out_data", bus.out_data, m_dat);
    chk("done", done, m_done);
    chk("error", error, m_err);
    chk("write_signal", bus.write_signal, 0);
    chk("data", bus.data, 0);
    chk("done_and_error", done && error, 0);
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (error) begin err_cnt++; err_cyc = cyc; end
    if (bus.read_signal) begin rd_log.push_back(int'(bus.address)); last_rd_cyc = cyc; end
    if (bus.out_valid && bus.out_ready) hs_log.push_back(int'(bus.out_data));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    mem[16'h0010] = 8'hA1; mem[16'h0011] = 8'hA2; mem[16'h0012] = 8'hA3;
    mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hC3;
    #1 RST = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_read", bus.read_signal, 0);
    chk("rst_address", bus.address, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_done_err", {done, error}, 0);
    repeat (2) @(negedge clk);
    RST = 1'b1;
    step();

    clr_logs(); lat_mode = 0; rdy_mode = 0;
    pulse_start(16'h0010, 16'd3);
    run_until_idle(40, "b3_timeout");
    step();
    chk("b3_reads", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      chk("b3_addr0", rd_log[0], 32'h10);
      chk("b3_addr1", rd_log[1], 32'h11);
      chk("b3_addr2", rd_log[2], 32'h12);
    end
    chk("b3_words", hs_log.size(), 3);
    if (hs_log.size() == 3) chk("b3_data", {hs_log[0][7:0], hs_log[1][7:0], hs_log[2][7:0]}, 24'hA1A2A3);
    chk("b3_busy_cycles", busy_cnt, 9);
    chk("b3_done", done_cnt, 1);
    chk("b3_err", err_cnt, 0);

    clr_logs();
    pulse_start(16'hFFFF, 16'd2);
    run_until_idle(40, "wrap_timeout");
    step();
    chk("wrap_reads", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      chk("wrap_addr0", rd_log[0], 32'hFFFF);
      chk("wrap_addr1", rd_log[1], 32'h0000);
    end
    chk("wrap_done", done_cnt, 1);

    clr_logs();
    pulse_start(16'h1234, 16'd0);
    repeat (4) step();
    chk("len0_done", done_cnt, 1);
    chk("len0_busy", busy_cnt, 0);
    chk("len0_reads", rd_log.size(), 0);
    chk("len0_words", hs_log.size(), 0);

    clr_logs(); lat_mode = 2;
    pulse_start(16'h0005, 16'd1);
    run_until_idle(40, "to_timeout");
    step();
    chk("to_err", err_cnt, 1);
    chk("to_done", done_cnt, 0);
    chk("to_delay", err_cyc - last_rd_cyc, 16);

    clr_logs(); lat_mode = 0; rdy_mode = 2;
    pulse_start(16'h0040, 16'd2);
    wait_valid(10, "hold_timeout");
    repeat (5) step();
    chk("hold_valid", bus.out_valid, 1);
    chk("hold_data", bus.out_data, mem[16'h0040]);
    chk("hold_reads", rd_log.size(), 1);
    chk("hold_words", hs_log.size(), 0);
    rdy_mode = 0;
    run_until_idle(20, "hold_end_timeout");
    step();
    chk("hold_reads_end", rd_log.size(), 2);
    chk("hold_done", done_cnt, 1);

    clr_logs(); lat_mode = 2;
    pulse_start(16'h0100, 16'd4);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    repeat (20) step();
    chk("abort_done", done_cnt, 0);
    chk("abort_err", err_cnt, 0);
    chk("abort_reads", rd_log.size(), 1);

    lat_mode = 0; rdy_mode = 2;
    pulse_start(16'h0200, 16'd3);
    wait_valid(10, "rst_hold_timeout");
    @(posedge clk); #3;
    RST = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_address", bus.address, 0);
    chk("arst_out_data", bus.out_data, 0);
    rdy_mode = 0;
    @(negedge clk);
    RST = 1'b1;
    clr_logs();
    repeat (5) step();
    chk("arst_idle_busy", busy_cnt, 0);
    chk("arst_idle_reads", rd_log.size(), 0);

    lat_mode = 1; rdy_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      start = $urandom_range(0, 5) == 0;
      abort = $urandom_range(0, 39) == 0;
      base_addr = $urandom_range(0, 3) == 0 ? 16'(16'hFFFD + $urandom_range(0, 2)) : 16'($urandom);
      length = 16'($urandom_range(0, 5));
      step();
    end
    start = 1'b0; abort = 1'b0; rdy_mode = 0; lat_mode = 0;
    run_until_idle(200, "rand_drain");
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
